// File: rtl/pattern_sequencer.sv
// pattern_sequencer
//
// Holds a small table of symbols and plays them back one per enable strobe
// into a downstream Mealy detector. While playing, it counts how many strobes
// the detector reported a hit on.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   en         : playback pacing strobe (one symbol per strobe while running)
//   load       : append load_data to the table (idle only, ignored when full)
//   load_data  : symbol to append
//   clear      : empty the table (idle only, wins over load)
//   start      : begin playback (idle only, needs a non-empty table)
//   stop       : abort playback, no done pulse, wins over en
//   loop       : level, wrap to the first entry instead of finishing
//   det_in     : detector hit flag, sampled on strobes while running
//   sym_out    : last symbol issued
//   sym_valid  : one-cycle pulse when sym_out has just been updated
//   busy       : high while playing
//   done       : one-cycle pulse after a normal (non-looping) end of playback
//   length     : number of entries in the table
//   det_count  : saturating hit count of the current or most recent run
module pattern_sequencer #(
  parameter int DEPTH = 8,
  parameter int SYM_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load,
  input  logic [SYM_W-1:0]         load_data,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     det_in,
  output logic [SYM_W-1:0]         sym_out,
  output logic                     sym_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   length,
  output logic [CNT_W-1:0]         det_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, next_state;

  logic [SYM_W-1:0] sym_table [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic             last_entry;
  logic             issue;
  logic             accept_start;

  // rd_ptr is one bit narrower than length, so widen it before comparing.
  assign last_entry = ({1'b0, rd_ptr} == (length - LW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Stop is checked before en so an abort never issues a symbol in the same cycle.
  always_comb begin
    next_state   = state;
    issue        = 1'b0;
    accept_start = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start && (length != '0)) begin
          next_state   = RUN;
          accept_start = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (stop) begin
          next_state = IDLE;
        end else if (en) begin
          issue = 1'b1;
          if (last_entry && !loop) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Table contents are deliberately left out of reset; only length decides
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      length    <= '0;
      rd_ptr    <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      det_count <= '0;
    end else begin
      sym_valid <= issue;
      if (state == IDLE) begin
        if (clear) begin
          length <= '0;
        end else if (load && (length < LW'(DEPTH))) begin
          sym_table[length[AW-1:0]] <= load_data;
          length                    <= length + LW'(1);
        end
      end
      if (accept_start) begin
        rd_ptr    <= '0;
        det_count <= '0;
      end
      if (issue) begin
        sym_out <= sym_table[rd_ptr];
        rd_ptr  <= last_entry ? '0 : rd_ptr + AW'(1);
        if (det_in && (det_count != {CNT_W{1'b1}})) begin
          det_count <= det_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
